// File: rtl/flash_flag_writer_if.sv
// Shared CFI flash bus port of the flag writer: bus request/grant plus the flash pins it drives.
// master = writer side, slave = top-level access mux / flash side.
interface flash_flag_writer_if;
  logic        fw_bus_req;
  logic        fw_bus_gnt;
  logic        fw_cen;
  logic        fw_oen;
  logic        fw_wen;
  logic [24:0] fw_addr;
  logic [15:0] fw_d_out;
  logic        fw_d_oe;
  logic [15:0] fw_d_in;

  modport master (
    output fw_bus_req, fw_cen, fw_oen, fw_wen, fw_addr, fw_d_out, fw_d_oe,
    input  fw_bus_gnt, fw_d_in
  );

  modport slave (
    input  fw_bus_req, fw_cen, fw_oen, fw_wen, fw_addr, fw_d_out, fw_d_oe,
    output fw_bus_gnt, fw_d_in
  );
endinterface

// File: rtl/flash_flag_writer.sv
// Programs {MAGIC, flag} at FLAG_ADDR in Intel-command-set CFI flash, then restores read-array mode.
// Define FLASH_FLAG_VERIFY_EN to add a readback check after the final 0xFF command.
module flash_flag_writer #(
  parameter logic [24:0] FLAG_ADDR  = 25'h0000100,
  parameter logic [13:0] MAGIC      = 14'h2A5C,
  parameter int unsigned WE_PULSE   = 4,
  parameter int unsigned RD_WAIT    = 6,
  parameter int unsigned POLL_LIMIT = 500000
) (
  input  logic                       clk,
  input  logic                       sys_resetn,
  input  logic                       wr_req,
  input  logic [1:0]                 wr_flag,
  output logic                       wr_busy,
  output logic                       wr_done,
  output logic                       wr_err,
  flash_flag_writer_if.master        bus
);

  localparam int unsigned CntMax = ((WE_PULSE + 1) > RD_WAIT) ? (WE_PULSE + 1) : RD_WAIT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] WePulse  = CntW'(WE_PULSE);
  localparam logic [CntW-1:0] WrLast   = CntW'(WE_PULSE + 1);
  localparam logic [CntW-1:0] RdSample = CntW'(RD_WAIT - 1);
  localparam logic [CntW-1:0] RdLast   = CntW'(RD_WAIT);
  localparam logic [19:0]     PollLast = 20'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StWaitGnt,
    StUnlk1,
    StUnlk2,
    StClrSr,
    StPgmCmd,
    StPgmData,
    StPoll,
    StChkSr,
    StRdArr,
`ifdef FLASH_FLAG_VERIFY_EN
    StVerify,
`endif
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [19:0]     poll_q, poll_d;
  logic [1:0]      flag_q, flag_d;
  logic            err_q, err_d;
  logic [15:0]     sr_q, sr_d;

  logic            cen_q, cen_d, oen_q, oen_d, wen_q, wen_d, doe_q, doe_d, breq_q, breq_d;
  logic [24:0]     addr_q, addr_d;
  logic [15:0]     dout_q, dout_d, cmd_d;
  logic            busy_q, done_q;
  logic            is_rd;

  // Only the ready and error bits of the status register steer the sequence.
  logic unused_sr;
  assign unused_sr = ^{sr_q[15:8], sr_q[6:5], sr_q[2], sr_q[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    flag_d  = flag_q;
    err_d   = err_q;
    sr_d    = sr_q;
    case (state_q)
      StIdle: begin
        if (wr_req) begin
          flag_d = wr_flag;
          err_d  = 1'b0;
          poll_d = '0;
          cnt_d  = '0;
          if (wr_flag == 2'b11) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWaitGnt;
          end
        end
      end
      StWaitGnt: begin
        if (bus.fw_bus_gnt) begin
          cnt_d   = '0;
          state_d = StUnlk1;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        // Losing the grant abandons the sequence; the owner of the bus must reissue 0xFF.
        if (!bus.fw_bus_gnt) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          case (state_q)
            StUnlk1:   if (cnt_q == WrLast) begin cnt_d = '0; state_d = StUnlk2;   end
            StUnlk2:   if (cnt_q == WrLast) begin cnt_d = '0; state_d = StClrSr;   end
            StClrSr:   if (cnt_q == WrLast) begin cnt_d = '0; state_d = StPgmCmd;  end
            StPgmCmd:  if (cnt_q == WrLast) begin cnt_d = '0; state_d = StPgmData; end
            StPgmData: if (cnt_q == WrLast) begin cnt_d = '0; state_d = StPoll;    end
            StPoll: begin
              if (cnt_q == RdSample) sr_d = bus.fw_d_in;
              if (cnt_q == RdLast) begin
                cnt_d = '0;
                if (sr_q[7]) begin
                  state_d = StChkSr;
                end else if (poll_q == PollLast) begin
                  err_d   = 1'b1;
                  state_d = StRdArr;
                end else begin
                  poll_d = poll_q + 20'd1;
                end
              end
            end
            StChkSr: begin
              cnt_d = '0;
              if (sr_q[4] | sr_q[3] | sr_q[1]) err_d = 1'b1;
              state_d = StRdArr;
            end
            StRdArr: begin
              if (cnt_q == WrLast) begin
                cnt_d = '0;
`ifdef FLASH_FLAG_VERIFY_EN
                state_d = err_q ? StDone : StVerify;
`else
                state_d = StDone;
`endif
              end
            end
`ifdef FLASH_FLAG_VERIFY_EN
            StVerify: begin
              if (cnt_q == RdSample && bus.fw_d_in != {MAGIC, flag_q}) err_d = 1'b1;
              if (cnt_q == RdLast) begin
                cnt_d   = '0;
                state_d = StDone;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    endcase
  end

  // Bus pins are decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    is_rd = (state_d == StPoll);
`ifdef FLASH_FLAG_VERIFY_EN
    is_rd = is_rd | (state_d == StVerify);
`endif
    case (state_d)
      StUnlk1:   cmd_d = 16'h0060;
      StUnlk2:   cmd_d = 16'h00D0;
      StClrSr:   cmd_d = 16'h0050;
      StPgmCmd:  cmd_d = 16'h0040;
      StPgmData: cmd_d = {MAGIC, flag_d};
      default:   cmd_d = 16'h00FF;
    endcase
    cen_d  = 1'b1;
    oen_d  = 1'b1;
    wen_d  = 1'b1;
    doe_d  = 1'b0;
    breq_d = 1'b0;
    addr_d = '0;
    dout_d = '0;
    if (state_d == StWaitGnt || state_d == StChkSr) begin
      breq_d = 1'b1;
    end else if (is_rd) begin
      breq_d = 1'b1;
      addr_d = FLAG_ADDR;
      if (cnt_d < RdLast) begin
        cen_d = 1'b0;
        oen_d = 1'b0;
      end
    end else if (state_d != StIdle && state_d != StDone) begin
      // Write cycle: setup (cnt 0), WE# low for WE_PULSE clocks, then one hold clock.
      breq_d = 1'b1;
      cen_d  = 1'b0;
      doe_d  = 1'b1;
      addr_d = FLAG_ADDR;
      dout_d = cmd_d;
      wen_d  = !((cnt_d != '0) && (cnt_d <= WePulse));
    end
  end

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      poll_q  <= '0;
      flag_q  <= '0;
      err_q   <= 1'b0;
      sr_q    <= '0;
      cen_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      doe_q   <= 1'b0;
      breq_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      sr_q    <= sr_d;
      cen_q   <= cen_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      doe_q   <= doe_d;
      breq_q  <= breq_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_q == StDone);
    end
  end

  assign wr_busy        = busy_q;
  assign wr_done        = done_q;
  assign wr_err         = err_q;
  assign bus.fw_bus_req = breq_q;
  assign bus.fw_cen     = cen_q;
  assign bus.fw_oen     = oen_q;
  assign bus.fw_wen     = wen_q;
  assign bus.fw_addr    = addr_q;
  assign bus.fw_d_out   = dout_q;
  assign bus.fw_d_oe    = doe_q;

endmodule

// File: tb/tb_flash_flag_writer.sv
// Bench for flash_flag_writer: small CFI flash model, write/done scoreboard, directed scenarios.
// Build with FLASH_FLAG_VERIFY_EN defined to cover the readback variant.
module tb_flash_flag_writer;
  localparam logic [24:0] FlagAddr = 25'h0000100;

  logic       clk = 1'b0;
  logic       sys_resetn = 1'b1;
  logic       wr_req = 1'b0;
  logic [1:0] wr_flag = 2'b00;
  logic       wr_busy, wr_done, wr_err;
  logic       gnt = 1'b0;

  flash_flag_writer_if bus();

  flash_flag_writer #(
    .POLL_LIMIT(16)
  ) dut (
    .clk       (clk),
    .sys_resetn(sys_resetn),
    .wr_req    (wr_req),
    .wr_flag   (wr_flag),
    .wr_busy   (wr_busy),
    .wr_done   (wr_done),
    .wr_err    (wr_err),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [40:0] exp_wr_q[$];   // {addr, data} of each expected completed bus write
  logic        exp_done_q[$]; // wr_err expected alongside each done pulse

  // Flash model: status mode after any command but 0xFF; SR reads ready from read sr_ready_at on.
  logic [15:0] last_cmd = 16'h00FF;
  logic [15:0] sr_value = 16'h0000;
  logic [15:0] array_value = 16'h0000;
  int          reads = 0, read_base = 0, sr_ready_at = 1;
  int          wr_count = 0, wr_base = 0, abort_count = 0, done_count = 0;
  int          breq_cycles = 0, cen_cycles = 0;

  assign bus.fw_bus_gnt = gnt;
  assign bus.fw_d_in = (last_cmd == 16'h00FF) ? array_value :
                       ((reads - read_base >= sr_ready_at) ? sr_value : 16'h0000);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT completes a write or pulses done.
  initial begin : monitor
    logic        prev_wen = 1'b1;
    logic        prev_oen = 1'b1;
    int          low = 0;
    logic [40:0] e;
    forever begin
      @(negedge clk);
      if (bus.fw_bus_req) breq_cycles++;
      if (!bus.fw_cen) cen_cycles++;
      if (!bus.fw_oen && prev_oen) reads++;
      if (!bus.fw_wen) begin
        low++;
      end else if (!prev_wen) begin
        if (bus.fw_cen) begin
          abort_count++;
        end else if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected write: got %0h @%0h expected none", bus.fw_d_out, bus.fw_addr);
        end else begin
          e = exp_wr_q.pop_front();
          chk("bus write {d_oe,addr,data,wen_low}",
              {bus.fw_d_oe, bus.fw_addr, bus.fw_d_out, 8'(low)}, {1'b1, e, 8'd4});
          last_cmd = bus.fw_d_out;
          wr_count++;
        end
        low = 0;
      end
      prev_wen = bus.fw_wen;
      prev_oen = bus.fw_oen;
      if (wr_done) begin
        done_count++;
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: got err=%0b expected no pulse", wr_err);
        end else begin
          chk("done err", wr_err, exp_done_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_writes(input logic [15:0] data, input int n);
    logic [15:0] seq[6];
    seq = '{16'h0060, 16'h00D0, 16'h0050, 16'h0040, data, 16'h00FF};
    for (int i = 0; i < n; i++) exp_wr_q.push_back({FlagAddr, seq[i]});
  endtask

  task automatic start(input logic [1:0] f);
    @(negedge clk);
    read_base = reads;
    wr_base   = wr_count;
    wr_flag   = f;
    wr_req    = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base = done_count;
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      ok = (done_count != base);
    end
    chk({name, " done seen"}, ok, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_pulse_after(input int nwr, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = (wr_count - wr_base == nwr) && !bus.fw_wen;
    end
    chk({name, " reached"}, ok, 1'b1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, " ctl"}, {bus.fw_cen, bus.fw_oen, bus.fw_wen, bus.fw_d_oe, bus.fw_bus_req,
                         wr_busy, wr_done, wr_err}, 8'b1110_0000);
    chk({name, " addr"}, bus.fw_addr, 25'h0);
    chk({name, " dout"}, bus.fw_d_out, 16'h0);
  endtask

  task automatic flag11_run(input string name);
    int lat = 0;
    int b0 = breq_cycles;
    int c0 = cen_cycles;
    bit seen = 1'b0;
    exp_done_q.push_back(1'b1);
    @(negedge clk);
    wr_flag = 2'b11;
    wr_req  = 1'b1;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      wr_req = 1'b0;
      seen = wr_done;
    end
    chk({name, " done latency"}, lat, 2);
    repeat (2) @(negedge clk);
    chk({name, " no bus_req"}, breq_cycles - b0, 0);
    chk({name, " no cen"}, cen_cycles - c0, 0);
  endtask

  initial begin : stimulus
    int a0;
    #5 sys_resetn = 1'b0;
    #1 chk_reset("reset async");
    repeat (3) @(negedge clk);
    chk_reset("reset held");
    sys_resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: flag 01, grant two clocks after request, ready on third poll
    gnt = 1'b0; sr_value = 16'h0080; sr_ready_at = 3; array_value = 16'hA971;
    push_writes(16'hA971, 6);
    exp_done_q.push_back(1'b0);
    start(2'b01);
    chk("t1 busy after accept", wr_busy, 1'b1);
    chk("t1 bus_req raised", bus.fw_bus_req, 1'b1);
    repeat (2) @(negedge clk);
    gnt = 1'b1;
    wait_done("t1");
`ifdef FLASH_FLAG_VERIFY_EN
    chk("t1 read cycles", reads - read_base, 4);
`else
    chk("t1 read cycles", reads - read_base, 3);
`endif
    chk("t1 writes drained", exp_wr_q.size(), 0);

    // 2: invalid flag finishes without touching the bus
    flag11_run("t2");

    // 3: program error in SR, err sticky until next accept
    sr_value = 16'h0090; sr_ready_at = 1;
    push_writes(16'hA972, 6);
    exp_done_q.push_back(1'b1);
    start(2'b10);
    wait_done("t3");
    repeat (5) @(negedge clk);
    chk("t3 err sticky", wr_err, 1'b1);

    // 4: SR never ready, timeout after 16 polls
    sr_value = 16'h0000; sr_ready_at = 1000;
    push_writes(16'hA970, 6);
    exp_done_q.push_back(1'b1);
    start(2'b00);
    chk("t4 err cleared on accept", wr_err, 1'b0);
    wait_done("t4");
    chk("t4 poll count", reads - read_base, 16);

    // 5: grant lost during the data write pulse
    a0 = abort_count;
    push_writes(16'hA971, 4);
    exp_done_q.push_back(1'b1);
    start(2'b01);
    wait_pulse_after(4, "t5 PGM_DATA pulse");
    gnt = 1'b0;
    @(negedge clk);
    chk("t5 release {cen,wen,oen,d_oe,bus_req}",
        {bus.fw_cen, bus.fw_wen, bus.fw_oen, bus.fw_d_oe, bus.fw_bus_req}, 5'b11100);
    chk("t5 err", wr_err, 1'b1);
    wait_done("t5");
    chk("t5 aborted write", abort_count - a0, 1);

    // 6: readback mismatch only matters with verify built in
    gnt = 1'b1; sr_value = 16'h0080; sr_ready_at = 1; array_value = 16'hA970;
    push_writes(16'hA971, 6);
`ifdef FLASH_FLAG_VERIFY_EN
    exp_done_q.push_back(1'b1);
`else
    exp_done_q.push_back(1'b0);
`endif
    start(2'b01);
    wait_done("t6");
`ifdef FLASH_FLAG_VERIFY_EN
    chk("t6 read cycles", reads - read_base, 2);
`else
    chk("t6 read cycles", reads - read_base, 1);
`endif

    // 7: asynchronous reset during the program-command pulse
    a0 = abort_count;
    push_writes(16'hA971, 3);
    start(2'b01);
    wait_pulse_after(3, "t7 PGM_CMD pulse");
    #2 sys_resetn = 1'b0;
    #1 chk_reset("t7 async reset");
    repeat (2) @(negedge clk);
    sys_resetn = 1'b1;
    chk("t7 aborted write", abort_count - a0, 1);
    @(negedge clk);
    chk("t7 idle busy", wr_busy, 1'b0);
    flag11_run("t7 idle after reset");

    chk("write queue drained", exp_wr_q.size(), 0);
    chk("done queue drained", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
